demux_dispatch_ctrl: RTL and testbench
======================================

// Module: demux_dispatch_ctrl
// PURPOSE
//  Sequencing controller for the 1-to-4 demux datapath. Accepts a valid/ready input stream,
//  picks one of 4 destinations (explicit select or round-robin), holds the word in a one-entry
//  output register and steers valid to exactly one channel until that channel accepts.
//  Sits between a single producer and four consumer channels.
// PARAMETERS
//  DATA_W  8  width of data word routed to outputs
//  CNT_W   16 width of each per-channel statistics counter (DEMUX_STATS_EN only)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous, active-high reset
//  in_valid   in   1         producer word valid
//  in_ready   out  1         controller can accept this cycle
//  in_data    in   DATA_W    producer word
//  in_sel     in   2         destination channel when mode=0
//  mode       in   1         0 = explicit select, 1 = round-robin
//  flush      in   1         synchronous drop of held word
//  out_valid  out  4         one-hot channel valid
//  out_ready  in   4         per-channel ready
//  out_data   out  DATA_W    held word, shared by all channels
//  busy       out  1         1 while a word is held
//  stat_cnt   out  4*CNT_W   per-channel delivered count, ch0 in LSBs
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, out_data=0, busy=0, rr_ptr=0, stat_cnt=0; in_ready=0 in reset.
//  - FSM states: IDLE (empty), HOLD (word held). Accept = in_valid & in_ready.
//  - in_ready = !flush & (IDLE | (HOLD & out_ready[dst])); back-to-back accept with no bubble.
//  - IDLE -accept-> HOLD; HOLD -deliver & !accept-> IDLE; HOLD -deliver & accept-> HOLD (new word).
//  - Deliver = out_valid[dst] & out_ready[dst]. Latency: word accepted at edge N is visible
//    on out_data/out_valid after edge N, i.e. in cycle N+1.
//  - dst latched at accept: mode=0 -> in_sel; mode=1 -> rr_ptr. rr_ptr advances by 1 on
//    every accept in mode=1 only, wraps 3->0. mode change takes effect on next accept.
//  - out_valid one-hot or zero; out_data and dst stable while HOLD and not delivered.
//  - out_ready on non-selected channels ignored.
//  - flush: held word dropped, next state IDLE, in_ready=0 that cycle; flush wins over
//    deliver and accept in the same cycle (no count increment). rr_ptr unaffected.
//  - Reset mid-HOLD: word discarded, all outputs to reset values immediately (async).
// CONFIGURATION
//  DEMUX_STATS_EN defined: stat_cnt[ch] increments by 1 on each deliver to ch, saturates at
//   2^CNT_W-1, never wraps; cleared only by rst.
//  DEMUX_STATS_EN undefined: counters not built, stat_cnt tied to 0; port list unchanged.
// STRUCTURE
//  - Package demux_ctrl_pkg: state enum (IDLE, HOLD), N_CH=4, SEL_W=2 localparams.
//  - Sub-module demux_onehot_4: combinational sel[1:0] + valid -> 4-bit one-hot out_valid;
//    instantiated once, driven by latched dst and busy.
//  - Top holds FSM, data/dst registers, rr_ptr, optional counters.
// TESTING
//  1 Reset: rst=1 mid-HOLD -> out_valid=0000, busy=0, out_data=0, rr_ptr=0 same cycle.
//  2 mode=0, in_sel=2, data=0xA5, out_ready=0100 -> out_valid=0100 next cycle, delivered, IDLE.
//  3 mode=0, sel=1, out_ready=0000 for 5 cycles -> out_valid=0010 held, data stable, in_ready=0;
//    then out_ready=0010 with new in_valid -> deliver and accept same cycle, no bubble.
//  4 mode=1, 6 words 0x10..0x15, out_ready=1111 -> channels 0,1,2,3,0,1; rr_ptr wraps to 2.
//  5 HOLD with flush=1 and out_ready[dst]=1 and in_valid=1 -> no delivery, no accept, IDLE.
//  6 DEMUX_STATS_EN, CNT_W=2: 5 delivers to ch3 -> stat_cnt[ch3]=3 (saturated), others 0;
//    without macro stat_cnt=0 throughout.

Source files
------------

// File: rtl/demux_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : demux_ctrl_pkg
// Brief  : Shared types and sizes for the 1-to-4 demux dispatch controller.
// Rev    : 1.0  initial release
// ============================================================================
package demux_ctrl_pkg;

   localparam int N_CH  = 4;
   localparam int SEL_W = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/demux_onehot_4.sv
`default_nettype none
// ============================================================================
// Module : demux_onehot_4
// Brief  : Combinational 2-bit select plus valid to 4-bit one-hot channel valid.
// Rev    : 1.0  initial release
// ============================================================================
module demux_onehot_4
   import demux_ctrl_pkg::*;
(
   input  logic [SEL_W-1:0] i_sel,
   input  logic             i_valid,
   output logic [N_CH-1:0]  o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_valid) o_onehot[i_sel] = 1'b1;
   end

endmodule
`default_nettype wire

// File: rtl/demux_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : demux_dispatch_ctrl
// Brief  : Valid/ready dispatcher holding one word and steering it to one of
//          four channels (explicit select or round-robin).
// Config : DEMUX_STATS_EN builds per-channel saturating delivery counters.
// Rev    : 1.0  initial release
// ============================================================================
module demux_dispatch_ctrl
   import demux_ctrl_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  mode,
   input  logic                  flush,
   output logic [N_CH-1:0]       out_valid,
   input  logic [N_CH-1:0]       out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic                  busy,
   output logic [N_CH*CNT_W-1:0] stat_cnt
);

   state_t             r_state;
   state_t             w_next;
   logic [SEL_W-1:0]   r_dst;
   logic [SEL_W-1:0]   r_rr_ptr;
   logic [DATA_W-1:0]  r_data;
   logic               w_accept;
   logic               w_deliver;
   logic               w_dst_ready;

   assign w_dst_ready = out_ready[r_dst];
   assign w_accept    = in_valid & in_ready;
   assign out_data    = r_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // flush overrides both delivery and a new accept in the same cycle
   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_accept) w_next = HOLD;
            HOLD:    if (w_deliver && !w_accept) w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (r_state == HOLD);
      in_ready  = !rst && !flush && ((r_state == IDLE) || w_dst_ready);
      w_deliver = busy && w_dst_ready && !flush;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data   <= '0;
         r_dst    <= '0;
         r_rr_ptr <= '0;
      end else if (w_accept) begin
         r_data <= in_data;
         r_dst  <= mode ? r_rr_ptr : in_sel;
         if (mode) r_rr_ptr <= r_rr_ptr + 1'b1;
      end
   end

   demux_onehot_4 u_onehot (
      .i_sel    (r_dst),
      .i_valid  (busy),
      .o_onehot (out_valid)
   );

`ifdef DEMUX_STATS_EN
   for (genvar g = 0; g < N_CH; g++) begin : g_stat
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            r_cnt <= '0;
         else if (w_deliver && (r_dst == SEL_W'(g)) && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
      end
      assign stat_cnt[g*CNT_W +: CNT_W] = r_cnt;
   end
`else
   assign stat_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_demux_dispatch_ctrl
// Brief  : Directed self-checking bench for demux_dispatch_ctrl (CNT_W=2).
// Rev    : 1.0  initial release
// ============================================================================
module tb_demux_dispatch_ctrl;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [1:0]        in_sel;
   logic              mode;
   logic              flush;
   logic [3:0]        out_valid;
   logic [3:0]        out_ready;
   logic [DATA_W-1:0] out_data;
   logic              busy;
   logic [4*CNT_W-1:0] stat_cnt;

   int n_chk = 0;
   int n_err = 0;

   demux_dispatch_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .mode      (mode),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .stat_cnt  (stat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] st(input logic [7:0] v);
`ifdef DEMUX_STATS_EN
      return {24'h0, v};
`else
      return 32'h0 & {24'h0, v};
`endif
   endfunction

   initial begin
      rst = 1'b1; in_valid = 0; in_data = 0; in_sel = 0; mode = 0; flush = 0; out_ready = 0;
      #2;
      check("rst_valid", out_valid, 0);
      check("rst_busy",  busy, 0);
      check("rst_ready", in_ready, 0);
      check("rst_data",  out_data, 0);
      check("rst_stat",  stat_cnt, 0);
      @(posedge clk); #1 rst = 1'b0;

      // explicit select to channel 2
      mode = 0; in_sel = 2; in_data = 8'hA5; in_valid = 1; out_ready = 4'b0100;
      #1 check("t2_in_ready", in_ready, 1);
      tick; in_valid = 0; #1;
      check("t2_valid", out_valid, 4'b0100);
      check("t2_data",  out_data, 8'hA5);
      check("t2_busy",  busy, 1);
      tick;
      check("t2_idle_busy",  busy, 0);
      check("t2_idle_valid", out_valid, 0);

      // backpressure on channel 1, then deliver-and-accept in one cycle
      in_sel = 1; in_data = 8'h3C; in_valid = 1; out_ready = 4'b0000;
      tick;
      in_sel = 3; in_data = 8'h77; #1;
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", out_valid, 4'b0010);
         check("t3_hold_data",  out_data, 8'h3C);
         check("t3_hold_ready", in_ready, 0);
         tick;
      end
      out_ready = 4'b0010; #1;
      check("t3_b2b_ready", in_ready, 1);
      tick;
      check("t3_b2b_valid", out_valid, 4'b1000);
      check("t3_b2b_data",  out_data, 8'h77);
      out_ready = 4'b1000; in_valid = 0;
      tick;
      check("t3_idle", busy, 0);

      // round-robin, six back-to-back words
      mode = 1; out_ready = 4'hF; in_valid = 1; in_data = 8'h10;
      tick;
      for (int i = 0; i < 6; i++) begin
         check("t4_rr_valid", out_valid, 32'(1 << (i % 4)));
         check("t4_rr_data",  out_data, 32'(8'h10 + i));
         if (i < 5) in_data = 8'(8'h11 + i);
         else       in_valid = 0;
         tick;
      end
      check("t4_idle", busy, 0);
      out_ready = 0; in_valid = 1; in_data = 8'h20;
      tick; in_valid = 0; #1;
      check("t4_rr_wrap2", out_valid, 4'b0100);

      // flush beats deliver and accept
      flush = 1; out_ready = 4'b0100; in_valid = 1; in_data = 8'h21; #1;
      check("t5_in_ready", in_ready, 0);
      tick; flush = 0; in_valid = 0; out_ready = 0; #1;
      check("t5_busy",  busy, 0);
      check("t5_valid", out_valid, 0);
      check("t5_stat",  stat_cnt, st(8'hAE));
      in_valid = 1; in_data = 8'h30;
      tick; in_valid = 0; #1;
      check("t5_rr_keep", out_valid, 4'b1000);
      check("t5_rr_data", out_data, 8'h30);

      // asynchronous reset while holding
      #2 rst = 1'b1; #1;
      check("t1_valid", out_valid, 0);
      check("t1_busy",  busy, 0);
      check("t1_data",  out_data, 0);
      check("t1_ready", in_ready, 0);
      check("t1_stat",  stat_cnt, 0);
      @(posedge clk); #1 rst = 1'b0;

      // five deliveries to channel 3 saturate a 2-bit counter
      mode = 0; in_sel = 3; out_ready = 4'b1000; in_valid = 1; in_data = 8'h40;
      tick;
      for (int i = 1; i < 5; i++) begin
         in_data = 8'(8'h40 + i);
         tick;
         if (i == 2) check("t6_stat2", stat_cnt, st(8'h80));
         if (i == 3) check("t6_stat3", stat_cnt, st(8'hC0));
      end
      in_valid = 0;
      tick;
      check("t6_stat5", stat_cnt, st(8'hC0));
      check("t6_idle",  busy, 0);

      // round-robin pointer restarts at channel 0 after reset
      mode = 1; out_ready = 4'b0001; in_valid = 1; in_data = 8'h50;
      tick; in_valid = 0; #1;
      check("t1_rr0_valid", out_valid, 4'b0001);
      check("t1_rr0_data",  out_data, 8'h50);
      tick;
      check("t1_rr0_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
